// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-access stage: op codes, access sizes, FSM states
// and small op-decode helpers.
package mem_lsu_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} mem_size_e;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} lsu_state_e;

    localparam int unsigned NOPRegAddr = 0;
    localparam int unsigned ZeroWord   = 0;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_signed_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW);
    endfunction

    function automatic mem_size_e mem_size(input logic [3:0] op);
        if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return SzByte;
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return SzHalf;
        return SzWord;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for mem_lsu (big-endian lanes: lane 0 = MSB byte).
//  op        in   memory op code
//  offset    in   byte offset within the bus word
//  st_data   in   right-justified store data
//  rdata     in   raw bus read data
//  sel       out  byte-lane enables
//  wdata     out  store data replicated across lanes
//  ld_data   out  extracted and extended load value
module mem_align
    import mem_lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned LANES  = DATA_W / 8,
    localparam int unsigned LANE_W = $clog2(LANES)
) (
    input  logic [3:0]        op,
    input  logic [LANE_W-1:0] offset,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [LANES-1:0]  sel,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ld_data
);

    mem_size_e         size;
    logic [LANES-1:0]  sel_base;
    logic [DATA_W-1:0] shifted;
    logic              sext;

    always_comb begin
        size     = mem_size(op);
        sext     = is_signed_load(op);
        sel_base = '0;
        wdata    = '0;
        ld_data  = '0;
        // Addressed lane moved to the top so extraction is a fixed slice.
        shifted  = rdata << {offset, 3'b000};
        case (size)
            SzByte: begin
                sel_base[LANES-1] = 1'b1;
                wdata   = {LANES{st_data[7:0]}};
                ld_data = DATA_W'(shifted[DATA_W-1 -: 8]);
                if (sext && shifted[DATA_W-1]) ld_data = ld_data | ~DATA_W'(8'hFF);
            end
            SzHalf: begin
                sel_base[LANES-1 -: 2] = 2'b11;
                wdata   = {(LANES / 2){st_data[15:0]}};
                ld_data = DATA_W'(shifted[DATA_W-1 -: 16]);
                if (sext && shifted[DATA_W-1]) ld_data = ld_data | ~DATA_W'(16'hFFFF);
            end
            default: begin
                sel_base[LANES-1 -: 4] = 4'hF;
                wdata   = {(LANES / 4){st_data[31:0]}};
                ld_data = DATA_W'(shifted[DATA_W-1 -: 32]);
                // Mask is all-zero on a 32-bit bus, so this only matters for 64-bit.
                if (sext && shifted[DATA_W-1]) ld_data = ld_data | ~DATA_W'(32'hFFFF_FFFF);
            end
        endcase
        sel = sel_base >> offset;
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: runs loads/stores over a req/ack bus, stalls upstream
// while busy, checks alignment, times out hung transfers. Non-memory ops pass through.
//  clk, rst (async, active-low)
//  wd/wreg/wdata/hi/lo/whilo _i -> _o   results forwarded to MEM/WB
//  mem_op_i, mem_addr_i, mem_wdata_i    memory op, byte address, store data
//  flush_i                              discard the instruction in this stage
//  stallreq_o, adel_o, ades_o, buserr_o stall request and exception pulses
//  dm_*                                 data-memory bus
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_W-1:0]   wd_i,
    input  logic                    wreg_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic [DATA_W-1:0]       hi_i,
    input  logic [DATA_W-1:0]       lo_i,
    input  logic                    whilo_i,
    input  logic [3:0]              mem_op_i,
    input  logic [ADDR_W-1:0]       mem_addr_i,
    input  logic [DATA_W-1:0]       mem_wdata_i,
    input  logic                    flush_i,
    output logic [REG_ADDR_W-1:0]   wd_o,
    output logic                    wreg_o,
    output logic [DATA_W-1:0]       wdata_o,
    output logic [DATA_W-1:0]       hi_o,
    output logic [DATA_W-1:0]       lo_o,
    output logic                    whilo_o,
    output logic                    stallreq_o,
    output logic                    adel_o,
    output logic                    ades_o,
    output logic                    buserr_o,
    output logic                    dm_req_o,
    output logic                    dm_we_o,
    output logic [ADDR_W-1:0]       dm_addr_o,
    output logic [DATA_W/8-1:0]     dm_sel_o,
    output logic [DATA_W-1:0]       dm_wdata_o,
    input  logic                    dm_ack_i,
    input  logic [DATA_W-1:0]       dm_rdata_i
);

    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 2);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [LANE_W-1:0] off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [LANES-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] st_q, st_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              timeout_q, timeout_d;
    logic              killed_q, killed_d;

    logic              in_ld, in_st, misaligned, start, busy, timed_out, clear;
    mem_size_e         in_size;
    logic [3:0]        al_op;
    logic [LANE_W-1:0] al_off;
    logic [LANES-1:0]  al_sel;
    logic [DATA_W-1:0] al_wdata, al_ld;

    always_comb begin
        in_ld      = is_load(mem_op_i);
        in_st      = is_store(mem_op_i);
        in_size    = mem_size(mem_op_i);
        misaligned = (in_ld || in_st) &&
                     ((in_size == SzHalf && mem_addr_i[0]) ||
                      (in_size == SzWord && mem_addr_i[1:0] != 2'b00));
        busy       = (state_q == StBusy);
        start      = (state_q == StIdle) && (in_ld || in_st) && !misaligned && !flush_i;
        timed_out  = busy && !dm_ack_i && (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
        // Live inputs set up the request; the registered op drives load extraction.
        al_op      = (state_q == StIdle) ? mem_op_i : op_q;
        al_off     = (state_q == StIdle) ? mem_addr_i[LANE_W-1:0] : off_q;
    end

    mem_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .op      (al_op),
        .offset  (al_off),
        .st_data (mem_wdata_i),
        .rdata   (dm_rdata_i),
        .sel     (al_sel),
        .wdata   (al_wdata),
        .ld_data (al_ld)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StBusy;
            StBusy:  if (dm_ack_i || timed_out) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request, counter and result registers.
    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        off_d     = off_q;
        addr_d    = addr_q;
        we_d      = we_q;
        sel_d     = sel_q;
        st_d      = st_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        killed_d  = killed_q;
        if (start) begin
            cnt_d     = '0;
            op_d      = mem_op_i;
            off_d     = mem_addr_i[LANE_W-1:0];
            addr_d    = {mem_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            we_d      = in_st;
            sel_d     = al_sel;
            st_d      = al_wdata;
            timeout_d = 1'b0;
            killed_d  = 1'b0;
        end
        if (busy) begin
            cnt_d = cnt_q + CNT_W'(1);
            // A flushed transfer still finishes on the bus; only its result is dropped.
            if (flush_i)   killed_d  = 1'b1;
            if (dm_ack_i)  result_d  = al_ld;
            if (timed_out) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            op_q      <= 4'd0;
            off_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            st_q      <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            killed_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            off_q     <= off_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            st_q      <= st_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            killed_q  <= killed_d;
        end
    end

    // Outputs.
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        hi_o       = hi_i;
        lo_o       = lo_i;
        whilo_o    = whilo_i;
        stallreq_o = 1'b0;
        adel_o     = 1'b0;
        ades_o     = 1'b0;
        buserr_o   = 1'b0;
        dm_req_o   = busy;
        dm_we_o    = busy & we_q;
        dm_addr_o  = busy ? addr_q : '0;
        dm_sel_o   = busy ? sel_q : '0;
        dm_wdata_o = busy ? st_q : '0;
        case (state_q)
            StIdle: begin
                if (misaligned) begin
                    adel_o = in_ld;
                    ades_o = in_st;
                    wreg_o = 1'b0;
                end else if (in_ld || in_st) begin
                    stallreq_o = 1'b1;
                    wreg_o     = 1'b0;
                end
            end
            StBusy: begin
                stallreq_o = 1'b1;
                wreg_o     = 1'b0;
            end
            StDone: begin
                if (is_load(op_q)) wdata_o = result_q;
                wreg_o   = is_load(op_q) & wreg_i & !timeout_q & !killed_q;
                buserr_o = timeout_q & !killed_q;
            end
            default: ;
        endcase
        // Reset and out-of-transfer flush present a bubble to MEM/WB.
        clear = !rst || (flush_i && !busy);
        if (clear) begin
            wd_o       = REG_ADDR_W'(NOPRegAddr);
            wreg_o     = 1'b0;
            wdata_o    = DATA_W'(ZeroWord);
            hi_o       = DATA_W'(ZeroWord);
            lo_o       = DATA_W'(ZeroWord);
            whilo_o    = 1'b0;
            stallreq_o = 1'b0;
            adel_o     = 1'b0;
            ades_o     = 1'b0;
            buserr_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, hi_i, lo_i;
    logic        whilo_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, hi_o, lo_o;
    logic        whilo_o, stallreq_o, adel_o, ades_o, buserr_o;
    logic        dm_req_o, dm_we_o;
    logic [31:0] dm_addr_o;
    logic [3:0]  dm_sel_o;
    logic [31:0] dm_wdata_o;
    logic        dm_ack_i;
    logic [31:0] dm_rdata_i;

    always #5 clk = ~clk;

    mem_lsu #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .REG_ADDR_W (5),
        .TIMEOUT    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .hi_i        (hi_i),
        .lo_i        (lo_i),
        .whilo_i     (whilo_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .flush_i     (flush_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .whilo_o     (whilo_o),
        .stallreq_o  (stallreq_o),
        .adel_o      (adel_o),
        .ades_o      (ades_o),
        .buserr_o    (buserr_o),
        .dm_req_o    (dm_req_o),
        .dm_we_o     (dm_we_o),
        .dm_addr_o   (dm_addr_o),
        .dm_sel_o    (dm_sel_o),
        .dm_wdata_o  (dm_wdata_o),
        .dm_ack_i    (dm_ack_i),
        .dm_rdata_i  (dm_rdata_i)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Single-cycle vectors: passthrough and misaligned accesses.
    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic        wreg;
        logic [31:0] wdata;
        logic        ack;
        logic        e_wreg;
        logic        e_adel;
        logic        e_ades;
    } vec_t;

    vec_t vecs[7];

    // Results captured by access().
    int          r_stalls, r_busy;
    logic [3:0]  r_sel;
    logic        r_we;
    logic [31:0] r_dwdata, r_daddr, r_wdata_o;
    logic        r_wreg_o, r_buserr, r_req_done;

    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int waits);
        bit done = 0;
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_wdata_i = sdata;
        wreg_i      = 1'b1;
        wd_i        = 5'd9;
        wdata_i     = 32'h0BAD_0000;
        r_stalls = 0;
        r_busy   = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            dm_ack_i = 1'b0;
            if (!stallreq_o) begin
                done       = 1;
                r_wdata_o  = wdata_o;
                r_wreg_o   = wreg_o;
                r_buserr   = buserr_o;
                r_req_done = dm_req_o;
            end else begin
                r_stalls++;
                if (dm_req_o) begin
                    if (r_busy == 0) begin
                        r_sel    = dm_sel_o;
                        r_we     = dm_we_o;
                        r_dwdata = dm_wdata_o;
                        r_daddr  = dm_addr_o;
                    end
                    if (r_busy == waits) begin
                        dm_ack_i   = 1'b1;
                        dm_rdata_i = rdata;
                    end
                    r_busy++;
                end
            end
        end
        if (!done) check("access_bound", 0, 1);
        @(posedge clk);
        #1;
        mem_op_i = MEM_NONE;
        wreg_i   = 1'b0;
        dm_ack_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{MEM_NONE, 32'h0,    1'b1, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{MEM_LW,   32'h1002, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{MEM_LH,   32'h1001, 1'b1, 32'h0000_2222, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{MEM_LHU,  32'h1003, 1'b1, 32'h0000_3333, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{MEM_SW,   32'h1001, 1'b0, 32'h0000_4444, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{MEM_SH,   32'h1003, 1'b0, 32'h0000_5555, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{MEM_NONE, 32'h0,    1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b0;
        wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h55; hi_i = 32'h1111_0000; lo_i = 32'h2222;
        whilo_i = 1'b1; mem_op_i = MEM_NONE; mem_addr_i = '0; mem_wdata_i = '0;
        flush_i = 1'b0; dm_ack_i = 1'b0; dm_rdata_i = '0;

        // Reset forces outputs to zero even with live inputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wd_o", wd_o, 0);
        check("rst_wreg_o", wreg_o, 0);
        check("rst_wdata_o", wdata_o, 0);
        check("rst_whilo_o", whilo_o, 0);
        check("rst_stall", stallreq_o, 0);
        check("rst_req", dm_req_o, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[i]) begin
            mem_op_i = vecs[i].op;
            mem_addr_i = vecs[i].addr;
            wreg_i = vecs[i].wreg;
            wdata_i = vecs[i].wdata;
            dm_ack_i = vecs[i].ack;
            @(negedge clk);
            check($sformatf("v%0d_wd", i), wd_o, 5'd3);
            check($sformatf("v%0d_wreg", i), wreg_o, vecs[i].e_wreg);
            check($sformatf("v%0d_wdata", i), wdata_o, vecs[i].wdata);
            check($sformatf("v%0d_hi", i), hi_o, 32'h1111_0000);
            check($sformatf("v%0d_stall", i), stallreq_o, 0);
            check($sformatf("v%0d_adel", i), adel_o, vecs[i].e_adel);
            check($sformatf("v%0d_ades", i), ades_o, vecs[i].e_ades);
            check($sformatf("v%0d_req", i), dm_req_o, 0);
            @(posedge clk);
            #1;
        end
        dm_ack_i = 1'b0;
        whilo_i = 1'b0;

        // LB, ack on first BUSY cycle.
        access(MEM_LB, 32'h0000_2001, 32'h0, 32'h118A_3344, 0);
        check("lb_sel", r_sel, 4'b0100);
        check("lb_addr", r_daddr, 32'h0000_2000);
        check("lb_we", r_we, 0);
        check("lb_stalls", r_stalls, 2);
        check("lb_wdata_o", r_wdata_o, 32'hFFFF_FF8A);
        check("lb_wreg_o", r_wreg_o, 1);

        // LHU, three wait states.
        access(MEM_LHU, 32'h0000_3002, 32'h0, 32'h1234_F00D, 3);
        check("lhu_sel", r_sel, 4'b0011);
        check("lhu_stalls", r_stalls, 5);
        check("lhu_wdata_o", r_wdata_o, 32'h0000_F00D);
        check("lhu_wreg_o", r_wreg_o, 1);

        // LH sign-extends a negative half from lane 0.
        access(MEM_LH, 32'h0000_3000, 32'h0, 32'h8001_7777, 1);
        check("lh_wdata_o", r_wdata_o, 32'hFFFF_8001);
        check("lh_stalls", r_stalls, 3);

        // SB to lane 3.
        access(MEM_SB, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0);
        check("sb_sel", r_sel, 4'b0001);
        check("sb_dwdata", r_dwdata, 32'hABAB_ABAB);
        check("sb_we", r_we, 1);
        check("sb_wreg_o", r_wreg_o, 0);

        // SH to lanes 2-3.
        access(MEM_SH, 32'h0000_1002, 32'hFFFF_BEEF, 32'h0, 0);
        check("sh_sel", r_sel, 4'b0011);
        check("sh_dwdata", r_dwdata, 32'hBEEF_BEEF);

        // No ack: request held for TIMEOUT cycles, then bus error.
        access(MEM_LW, 32'h0000_4000, 32'h0, 32'h0, 1000);
        check("to_busy", r_busy, 4);
        check("to_stalls", r_stalls, 5);
        check("to_buserr", r_buserr, 1);
        check("to_wreg_o", r_wreg_o, 0);
        check("to_req_done", r_req_done, 0);

        // Flush in IDLE: no request, bubble outputs.
        mem_op_i = MEM_LW; mem_addr_i = 32'h40; wreg_i = 1'b1; wd_i = 5'd7; flush_i = 1'b1;
        @(negedge clk);
        check("fidle_stall", stallreq_o, 0);
        check("fidle_wd", wd_o, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("fidle_req", dm_req_o, 0);
        @(posedge clk);
        #1 flush_i = 1'b0;

        // Flush in BUSY: transfer completes, result dropped.
        @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        check("fbusy_req", dm_req_o, 1);
        dm_ack_i = 1'b1;
        dm_rdata_i = 32'h1357_9BDF;
        @(posedge clk);
        #1 dm_ack_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        check("fbusy_stall", stallreq_o, 0);
        check("fbusy_wreg", wreg_o, 0);
        check("fbusy_wd", wd_o, 5'd7);
        @(posedge clk);
        #1 mem_op_i = MEM_NONE;
        wreg_i = 1'b0;

        // Reset in the middle of BUSY, then a clean LW.
        mem_op_i = MEM_LW; mem_addr_i = 32'h100; wreg_i = 1'b1; wdata_i = 32'h77;
        @(posedge clk);
        #2;
        check("rb_req_before", dm_req_o, 1);
        rst = 1'b0;
        #1;
        check("rb_req", dm_req_o, 0);
        check("rb_stall", stallreq_o, 0);
        check("rb_wreg", wreg_o, 0);
        check("rb_wdata", wdata_o, 0);
        check("rb_sel", dm_sel_o, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        access(MEM_LW, 32'h0000_0100, 32'h0, 32'hCAFE_BABE, 1);
        check("rb_lw_stalls", r_stalls, 3);
        check("rb_lw_wdata", r_wdata_o, 32'hCAFE_BABE);
        check("rb_lw_wreg", r_wreg_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
